// File: rtl/trap_ctrl_v2_if.sv
// Signal bundle between the core pipeline and the trap controller.
// The pipeline side is the master; trap_ctrl_v2 is the slave.
interface trap_ctrl_v2_if #(
    parameter int NUM_IRQ = 3
);
    logic               branch_taken;
    logic               jump_taken;
    logic [31:0]        branch_target;
    logic [31:0]        jump_target;
    logic               fence_i;
    logic [31:0]        pc_if;
    logic               wb_valid;
    logic [31:0]        pc_wb;
    logic               exc_valid_wb;
    logic [4:0]         exc_cause_wb;
    logic               mret_wb;
    logic [NUM_IRQ-1:0] irq_pending;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               mstatus_mie;
    logic [31:0]        mtvec;
    logic [31:0]        mepc;

    logic               set_pc_valid;
    logic [31:0]        set_pc;
    logic               mcause_update;
    logic [31:0]        mcause;
    logic               mepc_update;
    logic [31:0]        mepc_wdata;
    logic [4:0]         flush;
    logic               busy;

    modport master (
        output branch_taken, jump_taken, branch_target, jump_target, fence_i, pc_if,
               wb_valid, pc_wb, exc_valid_wb, exc_cause_wb, mret_wb,
               irq_pending, irq_mask, mstatus_mie, mtvec, mepc,
        input  set_pc_valid, set_pc, mcause_update, mcause, mepc_update, mepc_wdata,
               flush, busy
    );

    modport slave (
        input  branch_taken, jump_taken, branch_target, jump_target, fence_i, pc_if,
               wb_valid, pc_wb, exc_valid_wb, exc_cause_wb, mret_wb,
               irq_pending, irq_mask, mstatus_mie, mtvec, mepc,
        output set_pc_valid, set_pc, mcause_update, mcause, mepc_update, mepc_wdata,
               flush, busy
    );
endinterface

// File: rtl/trap_ctrl_v2.sv
// Pipeline redirect and trap controller: fetch redirects, WB traps/mret/interrupts,
// and a fixed-length full-pipeline flush before the trap target is fetched.
//
//  state   | meaning
//  S_IDLE  | normal flow; branch/jump/fence redirects pass through, traps accepted
//  S_FLUSH | all stages flushed; down-counter reaching 0 issues the latched redirect
module trap_ctrl_v2 #(
    parameter int NUM_IRQ      = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int VECTORED_EN  = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    trap_ctrl_v2_if.slave  bus
);
    localparam int            CW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(FLUSH_CYCLES - 1);

    typedef enum logic {S_IDLE, S_FLUSH} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   target_q, target_d;
    logic [31:0]   mcause_q, mcause_d;
    logic [31:0]   mepc_wdata_q, mepc_wdata_d;
    logic          strobe_q, strobe_d;

    logic          take_exc, take_mret, take_irq, accept;
    logic [4:0]    irq_code;
    logic [31:0]   tvec_base;
    logic          vec_mode;
    logic          set_pc_valid;
    logic [31:0]   set_pc;
    logic [4:0]    flush;

    function automatic logic [4:0] irq_cause(input int idx);
        case (idx)
            0:       return 5'd11;
            1:       return 5'd3;
            2:       return 5'd7;
            default: return 5'(idx + 13);
        endcase
    endfunction

    // Scan from the top so the lowest pending index is the one left standing.
    always_comb begin
        irq_code = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (bus.irq_pending[i] && bus.irq_mask[i]) begin
                irq_code = irq_cause(i);
            end
        end
    end

    assign take_exc  = bus.exc_valid_wb;
    assign take_mret = !bus.exc_valid_wb && bus.mret_wb;
    assign take_irq  = !bus.exc_valid_wb && !bus.mret_wb && bus.wb_valid && bus.mstatus_mie
                       && (|(bus.irq_pending & bus.irq_mask));
    assign accept    = take_exc || take_mret || take_irq;
    assign tvec_base = {bus.mtvec[31:2], 2'b00};
    assign vec_mode  = (VECTORED_EN != 0) && (bus.mtvec[1:0] == 2'b01);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        mcause_d     = mcause_q;
        mepc_wdata_d = mepc_wdata_q;
        strobe_d     = 1'b0;
        set_pc_valid = 1'b0;
        set_pc       = '0;
        flush        = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Trap is older than anything in EX, so its redirect wins outright.
                    flush    = 5'b11111;
                    state_d  = S_FLUSH;
                    cnt_d    = LOAD;
                    strobe_d = !take_mret;
                    if (take_exc) begin
                        mcause_d = {1'b0, 26'b0, bus.exc_cause_wb};
                    end
                    if (take_irq) begin
                        mcause_d = {1'b1, 26'b0, irq_code};
                    end
                    if (!take_mret) begin
                        mepc_wdata_d = bus.pc_wb;
                    end
                    if (take_mret) begin
                        target_d = bus.mepc;
                    end else if (take_irq && vec_mode) begin
                        target_d = tvec_base + {25'b0, irq_code, 2'b00};
                    end else begin
                        target_d = tvec_base;
                    end
                end else begin
                    set_pc_valid = bus.branch_taken || bus.jump_taken || bus.fence_i;
                    if (bus.branch_taken) begin
                        set_pc = bus.branch_target;
                    end else if (bus.jump_taken) begin
                        set_pc = bus.jump_target;
                    end else if (bus.fence_i) begin
                        set_pc = bus.pc_if;
                    end
                    flush = {3'b000, bus.branch_taken || bus.jump_taken,
                             bus.branch_taken || bus.jump_taken || bus.fence_i};
                end
            end
            S_FLUSH: begin
                flush = 5'b11111;
                if (cnt_q == '0) begin
                    set_pc_valid = 1'b1;
                    set_pc       = target_q;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            target_q     <= '0;
            mcause_q     <= '0;
            mepc_wdata_q <= '0;
            strobe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            mcause_q     <= mcause_d;
            mepc_wdata_q <= mepc_wdata_d;
            strobe_q     <= strobe_d;
        end
    end

    assign bus.set_pc_valid  = set_pc_valid;
    assign bus.set_pc        = set_pc;
    assign bus.flush         = flush;
    assign bus.mcause_update = strobe_q;
    assign bus.mepc_update   = strobe_q;
    assign bus.mcause        = mcause_q;
    assign bus.mepc_wdata    = mepc_wdata_q;
    assign bus.busy          = (state_q == S_FLUSH);
endmodule

// File: tb/tb_trap_ctrl_v2.sv
// Bench for trap_ctrl_v2: directed scenarios with literal expectations, then random
// traffic checked every cycle against a cycle-count model of the trap sequence.
module tb_trap_ctrl_v2;
    localparam int NIRQ = 3;
    localparam int FC   = 3;
    localparam int VEC  = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    trap_ctrl_v2_if #(.NUM_IRQ(NIRQ)) bus();

    trap_ctrl_v2 #(.NUM_IRQ(NIRQ), .FLUSH_CYCLES(FC), .VECTORED_EN(VEC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: rem = FLUSH cycles still to run (0 means idle).
    int          rem      = 0;
    logic [31:0] m_target = '0;
    logic [31:0] m_mcause = '0;
    logic [31:0] m_mepc   = '0;
    bit          m_upd    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lowest_irq();
        for (int i = 0; i < NIRQ; i++) begin
            if (bus.irq_pending[i] && bus.irq_mask[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [4:0] cause_of(input int idx);
        if (idx == 0) return 5'd11;
        if (idx == 1) return 5'd3;
        if (idx == 2) return 5'd7;
        return 5'(16 + idx - 3);
    endfunction

    // 0 none, 1 exception, 2 mret, 3 interrupt
    function automatic int ev_kind();
        if (bus.exc_valid_wb) return 1;
        if (bus.mret_wb) return 2;
        if (bus.wb_valid && bus.mstatus_mie && lowest_irq() >= 0) return 3;
        return 0;
    endfunction

    function automatic logic [31:0] target_of(input int k);
        logic [31:0] base;
        base = bus.mtvec & 32'hFFFF_FFFC;
        if (k == 2) return bus.mepc;
        if (k == 3 && VEC != 0 && bus.mtvec[1:0] == 2'b01)
            return base + (32'(cause_of(lowest_irq())) << 2);
        return base;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            rem      <= 0;
            m_upd    <= 1'b0;
            m_mcause <= '0;
            m_mepc   <= '0;
            m_target <= '0;
        end else if (rem > 0) begin
            rem   <= rem - 1;
            m_upd <= 1'b0;
        end else if (ev_kind() != 0) begin
            rem      <= FC;
            m_target <= target_of(ev_kind());
            m_upd    <= (ev_kind() != 2);
            if (ev_kind() == 1) begin
                m_mcause <= {1'b0, 26'b0, bus.exc_cause_wb};
                m_mepc   <= bus.pc_wb;
            end else if (ev_kind() == 3) begin
                m_mcause <= {1'b1, 26'b0, cause_of(lowest_irq())};
                m_mepc   <= bus.pc_wb;
            end
        end else begin
            m_upd <= 1'b0;
        end
    end

    task automatic compare_cycle();
        logic [4:0]  ef;
        logic        es;
        logic [31:0] ep;
        if (rem > 0) begin
            ef = 5'h1F;
            es = (rem == 1);
            ep = m_target;
        end else if (ev_kind() != 0) begin
            ef = 5'h1F;
            es = 1'b0;
            ep = '0;
        end else begin
            es = bus.branch_taken | bus.jump_taken | bus.fence_i;
            ep = bus.branch_taken ? bus.branch_target :
                 bus.jump_taken   ? bus.jump_target   : bus.pc_if;
            ef = {3'b000, bus.branch_taken | bus.jump_taken, es};
        end
        chk("busy", 32'(bus.busy), 32'(rem > 0));
        chk("flush", 32'(bus.flush), 32'(ef));
        chk("set_pc_valid", 32'(bus.set_pc_valid), 32'(es));
        if (es) chk("set_pc", bus.set_pc, ep);
        chk("mcause_update", 32'(bus.mcause_update), 32'(m_upd));
        chk("mepc_update", 32'(bus.mepc_update), 32'(m_upd));
        chk("mcause", bus.mcause, m_mcause);
        chk("mepc_wdata", bus.mepc_wdata, m_mepc);
    endtask

    always @(negedge clk) begin
        if (chk_en) compare_cycle();
    end

    task automatic drive_idle();
        bus.branch_taken  = 1'b0;
        bus.jump_taken    = 1'b0;
        bus.branch_target = '0;
        bus.jump_target   = '0;
        bus.fence_i       = 1'b0;
        bus.pc_if         = '0;
        bus.wb_valid      = 1'b0;
        bus.pc_wb         = '0;
        bus.exc_valid_wb  = 1'b0;
        bus.exc_cause_wb  = '0;
        bus.mret_wb       = 1'b0;
        bus.irq_pending   = '0;
        bus.irq_mask      = '0;
        bus.mstatus_mie   = 1'b0;
        bus.mtvec         = '0;
        bus.mepc          = '0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        logic [31:0] r;
        bus.branch_taken  = ($urandom_range(0, 3) == 0);
        bus.jump_taken    = ($urandom_range(0, 3) == 0);
        bus.fence_i       = ($urandom_range(0, 5) == 0);
        bus.branch_target = $urandom;
        bus.jump_target   = $urandom;
        bus.pc_if         = $urandom;
        bus.wb_valid      = ($urandom_range(0, 3) != 0);
        bus.pc_wb         = $urandom;
        bus.exc_valid_wb  = ($urandom_range(0, 11) == 0);
        bus.exc_cause_wb  = 5'($urandom);
        bus.mret_wb       = ($urandom_range(0, 11) == 0);
        bus.irq_pending   = NIRQ'($urandom);
        bus.irq_mask      = NIRQ'($urandom);
        bus.mstatus_mie   = ($urandom_range(0, 2) == 0);
        r                 = $urandom;
        bus.mtvec         = {r[31:2], ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00};
        bus.mepc          = $urandom;
    endtask

    int spv_seen;

    initial begin
        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en  = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mcause_update", 32'(bus.mcause_update), 32'd0);
        chk("rst_mcause", bus.mcause, 32'd0);
        chk("rst_mepc_wdata", bus.mepc_wdata, 32'd0);

        // branch redirect in IDLE
        next_cyc();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h100;
        @(negedge clk);
        chk("t1_set_pc_valid", 32'(bus.set_pc_valid), 32'd1);
        chk("t1_set_pc", bus.set_pc, 32'h100);
        chk("t1_flush", 32'(bus.flush), 32'h03);
        next_cyc();
        drive_idle();

        // exception, three flush cycles
        next_cyc();
        bus.wb_valid = 1'b1; bus.exc_valid_wb = 1'b1; bus.exc_cause_wb = 5'd2;
        bus.pc_wb = 32'h40; bus.mtvec = 32'h800;
        @(negedge clk);
        chk("t2_flush_T", 32'(bus.flush), 32'h1F);
        chk("t2_spv_T", 32'(bus.set_pc_valid), 32'd0);
        next_cyc(); drive_idle();
        @(negedge clk);
        chk("t2_mcause_update", 32'(bus.mcause_update), 32'd1);
        chk("t2_mepc_update", 32'(bus.mepc_update), 32'd1);
        chk("t2_mcause", bus.mcause, 32'h2);
        chk("t2_mepc_wdata", bus.mepc_wdata, 32'h40);
        chk("t2_spv_T1", 32'(bus.set_pc_valid), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t2_upd_T2", 32'(bus.mcause_update), 32'd0);
        chk("t2_spv_T2", 32'(bus.set_pc_valid), 32'd0);
        chk("t2_flush_T2", 32'(bus.flush), 32'h1F);
        next_cyc();
        @(negedge clk);
        chk("t2_spv_T3", 32'(bus.set_pc_valid), 32'd1);
        chk("t2_set_pc", bus.set_pc, 32'h800);
        next_cyc();
        @(negedge clk);
        chk("t2_busy_T4", 32'(bus.busy), 32'd0);

        // vectored interrupt, idx1 beats idx2
        next_cyc();
        bus.wb_valid = 1'b1; bus.mstatus_mie = 1'b1; bus.irq_pending = 3'b110;
        bus.irq_mask = 3'b111; bus.mtvec = 32'h801; bus.pc_wb = 32'h123;
        next_cyc(); drive_idle();
        @(negedge clk);
        chk("t3_mcause", bus.mcause, 32'h8000_0003);
        chk("t3_mepc_wdata", bus.mepc_wdata, 32'h123);
        next_cyc(); next_cyc();
        @(negedge clk);
        chk("t3_set_pc", bus.set_pc, 32'h80C);
        next_cyc();

        // exception beats branch and interrupt in the same cycle
        next_cyc();
        bus.wb_valid = 1'b1; bus.exc_valid_wb = 1'b1; bus.exc_cause_wb = 5'd5;
        bus.branch_taken = 1'b1; bus.branch_target = 32'h300;
        bus.mstatus_mie = 1'b1; bus.irq_pending = 3'b001; bus.irq_mask = 3'b001;
        bus.mtvec = 32'h801;
        @(negedge clk);
        chk("t4_spv_T", 32'(bus.set_pc_valid), 32'd0);
        next_cyc(); drive_idle();
        @(negedge clk);
        chk("t4_mcause", bus.mcause, 32'h5);
        next_cyc(); next_cyc();
        @(negedge clk);
        chk("t4_set_pc", bus.set_pc, 32'h800);
        next_cyc();

        // mret: no CSR strobes, mcause holds
        next_cyc();
        bus.mret_wb = 1'b1; bus.mepc = 32'h2000;
        next_cyc(); drive_idle();
        @(negedge clk);
        chk("t5_mcause_update", 32'(bus.mcause_update), 32'd0);
        chk("t5_mepc_update", 32'(bus.mepc_update), 32'd0);
        chk("t5_mcause_hold", bus.mcause, 32'h5);
        next_cyc(); next_cyc();
        @(negedge clk);
        chk("t5_set_pc", bus.set_pc, 32'h2000);
        next_cyc();

        // reset in the middle of FLUSH
        next_cyc();
        bus.exc_valid_wb = 1'b1; bus.exc_cause_wb = 5'd1; bus.pc_wb = 32'h44;
        next_cyc(); drive_idle();
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_busy_flush", 32'(bus.busy), 32'd1);
        next_cyc();
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_mcause", bus.mcause, 32'd0);
        spv_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.set_pc_valid) spv_seen++;
        end
        chk("t6_no_set_pc", 32'(spv_seen), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            next_cyc();
            drive_random();
            reset_n = ($urandom_range(0, 199) != 0);
        end
        next_cyc();
        drive_idle();
        reset_n = 1'b1;
        repeat (FC + 2) next_cyc();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
